// File: rtl/dma_65xx.sv
// Memory-to-memory DMA engine and bus arbiter for the 65xx SoC.
// Stalls the CPU through RDY and copies LEN bytes from SRC to DST through the shared bus.
module dma_65xx #(
    parameter int BURST = 16,
    parameter int BW    = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs_n,
    input  logic        we_n,
    input  logic [2:0]  rs,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we_n,
    output logic [15:0] bus_ab,
    output logic [7:0]  bus_do,
    output logic        bus_we_n,
    input  logic [7:0]  bus_di,
    output logic        rdy,
    output logic        irq_n,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_RD,
        S_CAP,
        S_WR,
        S_YIELD
    } state_t;

    localparam logic [BW-1:0] BURST_C = BW'(BURST);

    state_t        state_q, state_d;
    logic [15:0]   src_q, src_d;
    logic [15:0]   dst_q, dst_d;
    logic [15:0]   len_q, len_d;
    logic          src_inc_q, src_inc_d;
    logic          dst_inc_q, dst_inc_d;
    logic          irq_en_q, irq_en_d;
    logic          done_q, done_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    dout_q, dout_d;

    logic          reg_wr;
    logic          reg_rd;
    logic          done_set;
    logic          dma_owns_bus;
    logic [BW-1:0] burst_inc;
    logic [7:0]    rd_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            src_q     <= 16'h0000;
            dst_q     <= 16'h0000;
            len_q     <= 16'h0000;
            src_inc_q <= 1'b1;
            dst_inc_q <= 1'b1;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            burst_q   <= '0;
            data_q    <= 8'h00;
            dout_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            src_inc_q <= src_inc_d;
            dst_inc_q <= dst_inc_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            burst_q   <= burst_d;
            data_q    <= data_d;
            dout_q    <= dout_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign reg_wr    = !cs_n && !we_n && (state_q == S_IDLE);
    assign reg_rd    = !cs_n && we_n;
    assign burst_inc = burst_q + BW'(1);

    always_comb begin
        rd_val = 8'h00;
        case (rs)
            3'd0: rd_val = src_q[7:0];
            3'd1: rd_val = src_q[15:8];
            3'd2: rd_val = dst_q[7:0];
            3'd3: rd_val = dst_q[15:8];
            3'd4: rd_val = len_q[7:0];
            3'd5: rd_val = len_q[15:8];
            3'd6: rd_val = {4'b0000, irq_en_q, dst_inc_q, src_inc_q, 1'b0};
            3'd7: rd_val = {busy, 6'b000000, done_q};
            default: rd_val = 8'h00;
        endcase
    end

    // Register window and transfer sequencer; a done set always beats a clear on the same edge.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        src_inc_d = src_inc_q;
        dst_inc_d = dst_inc_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        burst_d   = burst_q;
        data_d    = data_q;
        dout_d    = dout_q;
        done_set  = 1'b0;

        if (reg_rd) begin
            dout_d = rd_val;
            if (rs == 3'd7) begin
                done_d = 1'b0;
            end
        end

        if (reg_wr) begin
            case (rs)
                3'd0: src_d[7:0]  = din;
                3'd1: src_d[15:8] = din;
                3'd2: dst_d[7:0]  = din;
                3'd3: dst_d[15:8] = din;
                3'd4: len_d[7:0]  = din;
                3'd5: len_d[15:8] = din;
                3'd6: begin
                    src_inc_d = din[1];
                    dst_inc_d = din[2];
                    irq_en_d  = din[3];
                    done_d    = 1'b0;
                    if (din[0]) begin
                        if (len_q == 16'h0000) begin
                            done_set = 1'b1;
                        end else begin
                            state_d = S_GRANT;
                        end
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: ;
            S_GRANT: begin
                burst_d = '0;
                state_d = S_RD;
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                data_d  = bus_di;
                state_d = S_WR;
            end
            S_WR: begin
                len_d   = len_q - 16'h0001;
                src_d   = src_q + {15'h0000, src_inc_q};
                dst_d   = dst_q + {15'h0000, dst_inc_q};
                burst_d = burst_inc;
                if (len_q == 16'h0001) begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end else if ((BURST != 0) && (burst_inc == BURST_C)) begin
                    state_d = S_YIELD;
                end else begin
                    state_d = S_RD;
                end
            end
            S_YIELD: state_d = S_GRANT;
            default: state_d = S_IDLE;
        endcase

        if (done_set) begin
            done_d = 1'b1;
        end
    end

    // The bus stays with the CPU in GRANT so it halts on a clean cycle before the engine takes over.
    always_comb begin
        dma_owns_bus = (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_WR);
        bus_ab       = cpu_ab;
        bus_do       = cpu_do;
        bus_we_n     = cpu_we_n;
        rdy          = 1'b1;
        if (dma_owns_bus) begin
            bus_ab   = (state_q == S_WR) ? dst_q : src_q;
            bus_do   = data_q;
            bus_we_n = (state_q != S_WR);
        end
        if ((state_q != S_IDLE) && (state_q != S_YIELD)) begin
            rdy = 1'b0;
        end
    end

    assign dout  = dout_q;
    assign irq_n = ~(done_q & irq_en_q);

endmodule

// File: tb/tb_dma_65xx.sv
// Self-checking bench for dma_65xx: a synchronous memory model on the shared bus and a
// scoreboard of expected destination writes.
module tb_dma_65xx;

    logic        clk;
    logic        reset_n;
    logic        cs_n;
    logic        we_n;
    logic [2:0]  rs;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we_n;
    logic [15:0] bus_ab;
    logic [7:0]  bus_do;
    logic        bus_we_n;
    logic [7:0]  bus_di;
    logic        rdy;
    logic        irq_n;
    logic        busy;

    dma_65xx #(.BURST(16), .BW(5)) dut (
        .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .we_n(we_n), .rs(rs), .din(din),
        .dout(dout), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we_n(cpu_we_n),
        .bus_ab(bus_ab), .bus_do(bus_do), .bus_we_n(bus_we_n), .bus_di(bus_di),
        .rdy(rdy), .irq_n(irq_n), .busy(busy)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic [7:0] mem     [0:65535];
    logic [7:0] exp_mem [0:65535];
    logic [7:0] rd_data;
    wr_t        exp_q[$];
    int         n_checks;
    int         n_pass;
    int         busy_cyc;
    int         yield_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: address presented in RD, data valid during CAP.
    always @(posedge clk) begin
        rd_data <= mem[bus_ab];
        if (!bus_we_n) mem[bus_ab] <= bus_do;
    end
    assign bus_di = rd_data;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (busy && rdy) begin
            yield_cnt++;
            checkOutput("yield_bus_ab", bus_ab, cpu_ab);
        end
        if (!bus_we_n) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("wr_addr", bus_ab, e.addr);
                checkOutput("wr_data", bus_do, e.data);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] r, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; we_n = 1'b0; rs = r; din = d;
        @(posedge clk);
        #1;
        cs_n = 1'b1; we_n = 1'b1;
    endtask

    task automatic readRegister(input logic [2:0] r, output logic [7:0] v);
        @(negedge clk);
        cs_n = 1'b0; we_n = 1'b1; rs = r;
        @(posedge clk);
        #1;
        cs_n = 1'b1;
        v = dout;
    endtask

    task automatic checkRegister(input string tag, input logic [2:0] r, input logic [7:0] expected);
        logic [7:0] v;
        readRegister(r, v);
        checkOutput(tag, v, expected);
    endtask

    task automatic startTransfer(input logic [15:0] src, input logic [15:0] dst,
                                 input logic [15:0] len, input logic [7:0] ctrl);
        logic [15:0] s;
        logic [15:0] d;
        logic [7:0]  v;
        applyStimulus(3'd0, src[7:0]);
        applyStimulus(3'd1, src[15:8]);
        applyStimulus(3'd2, dst[7:0]);
        applyStimulus(3'd3, dst[15:8]);
        applyStimulus(3'd4, len[7:0]);
        applyStimulus(3'd5, len[15:8]);
        s = src;
        d = dst;
        if (ctrl[0]) begin
            for (int i = 0; i < int'(len); i++) begin
                v = exp_mem[s];
                exp_q.push_back('{d, v});
                exp_mem[d] = v;
                if (ctrl[1]) s = s + 16'd1;
                if (ctrl[2]) d = d + 16'd1;
            end
        end
        busy_cyc  = 0;
        yield_cnt = 0;
        applyStimulus(3'd6, ctrl);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 1, 0);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; busy_cyc = 0; yield_cnt = 0;
        reset_n = 1'b0; cs_n = 1'b1; we_n = 1'b1; rs = 3'd0; din = 8'h00;
        cpu_ab = 16'hBEEF; cpu_do = 8'h5A; cpu_we_n = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
            exp_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        checkOutput("rst_rdy", rdy, 1);
        checkOutput("rst_irq_n", irq_n, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_bus_ab", bus_ab, 16'hBEEF);
        checkOutput("rst_bus_do", bus_do, 8'h5A);
        checkRegister("rst_ctrl", 3'd6, 8'h06);
        checkRegister("rst_status", 3'd7, 8'h00);
        checkRegister("rst_len_l", 3'd4, 8'h00);

        // Basic 4-byte incrementing copy
        startTransfer(16'h0100, 16'h0200, 16'd4, 8'h07);
        checkOutput("t1_rdy_low", rdy, 0);
        checkOutput("t1_busy", busy, 1);
        waitIdle(100);
        checkOutput("t1_busy_cycles", busy_cyc, 13);
        checkOutput("t1_sb_empty", exp_q.size(), 0);
        checkOutput("t1_irq_n", irq_n, 1);
        checkRegister("t1_len_l", 3'd4, 8'h00);
        checkRegister("t1_src_l", 3'd0, 8'h04);
        checkRegister("t1_src_h", 3'd1, 8'h01);
        checkRegister("t1_dst_l", 3'd2, 8'h04);
        checkRegister("t1_status", 3'd7, 8'h01);
        checkRegister("t1_status_clr", 3'd7, 8'h00);

        // 40 bytes with two burst yields; a register write mid-transfer must be ignored
        startTransfer(16'h1000, 16'h2000, 16'd40, 8'h07);
        repeat (3) @(negedge clk);
        applyStimulus(3'd1, 8'h77);
        waitIdle(400);
        checkOutput("t2_yields", yield_cnt, 2);
        checkOutput("t2_busy_cycles", busy_cyc, 125);
        checkOutput("t2_sb_empty", exp_q.size(), 0);
        checkRegister("t2_src_h", 3'd1, 8'h10);
        checkRegister("t2_src_l", 3'd0, 8'h28);

        // Fixed source
        mem[16'h0010] = 8'hA5;
        exp_mem[16'h0010] = 8'hA5;
        startTransfer(16'h0010, 16'h0400, 16'd3, 8'h05);
        waitIdle(100);
        checkOutput("t3_sb_empty", exp_q.size(), 0);
        checkRegister("t3_src_l", 3'd0, 8'h10);
        checkRegister("t3_dst_l", 3'd2, 8'h03);
        checkRegister("t3_ctrl", 3'd6, 8'h04);

        // Source address wrap
        startTransfer(16'hFFFE, 16'h0300, 16'd3, 8'h07);
        waitIdle(100);
        checkOutput("t4_sb_empty", exp_q.size(), 0);
        checkRegister("t4_src_l", 3'd0, 8'h01);
        checkRegister("t4_src_h", 3'd1, 8'h00);

        // Interrupt on completion, then a zero-length start
        startTransfer(16'h0500, 16'h0600, 16'd1, 8'h0F);
        waitIdle(100);
        checkOutput("t5_irq_low", irq_n, 0);
        checkRegister("t5_status", 3'd7, 8'h01);
        checkOutput("t5_irq_high", irq_n, 1);
        startTransfer(16'h0700, 16'h0800, 16'd0, 8'h0F);
        checkOutput("t5_len0_busy", busy, 0);
        checkOutput("t5_len0_irq", irq_n, 0);
        repeat (4) @(negedge clk);
        checkOutput("t5_len0_cycles", busy_cyc, 0);
        checkRegister("t5_len0_status", 3'd7, 8'h01);

        // Asynchronous reset while in RD
        applyStimulus(3'd4, 8'h08);
        applyStimulus(3'd6, 8'h07);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rdy", rdy, 1);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_bus_ab", bus_ab, 16'hBEEF);
        checkOutput("t6_bus_we_n", bus_we_n, 1);
        @(negedge clk);
        reset_n = 1'b1;
        checkRegister("t6_len_l", 3'd4, 8'h00);
        checkRegister("t6_src_h", 3'd1, 8'h00);
        checkRegister("t6_ctrl", 3'd6, 8'h06);
        checkRegister("t6_status", 3'd7, 8'h00);
        checkOutput("t6_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
